menu_button_pixel_gen: RTL and testbench

Parametrised menu renderer that replaces the fixed two-button menu pixel generator. It drives an external label-mask ROM and maps each returned region code to a 12-bit RGB pixel. It tracks hover, press and click state for `NUM_BUTTONS` buttons, and emits one-cycle click pulses on release. It sits between the VGA timing generator and the VGA output mux, with a latency-matched pixel pipeline.

---
 rtl/menu_pkg.sv | 48 ++++
 rtl/menu_button_fsm.sv | 57 +++++
 rtl/menu_button_pixel_gen.sv | 139 +++++++++++++
 tb/tb_menu_button_pixel_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared constants, button state type and colour helper for the menu renderer.
package menu_pkg;

   localparam int unsigned PIX_W  = 12;
   localparam int unsigned ADDR_W = 17;

   localparam logic [PIX_W-1:0] BLACK  = 12'h000;
   localparam logic [PIX_W-1:0] WHITE  = 12'hFFF;
   localparam logic [PIX_W-1:0] TOUCH  = 12'h32E;
   localparam logic [PIX_W-1:0] CLICK  = 12'hDD2;
   localparam logic [PIX_W-1:0] RECV   = 12'h7FF;
   localparam logic [PIX_W-1:0] SEND   = 12'h456;
   localparam logic [PIX_W-1:0] LINKED = 12'h1E1;

   // Mask ROM code of button 0; codes 0/1 are plain black/white.
   localparam int unsigned BTN_CODE_BASE = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOVER   = 2'd1,
      PRESSED = 2'd2
   } btn_state_t;

   // Colour of one button given its state, status-mode flag, link inputs and blink phase.
   function automatic logic [PIX_W-1:0] button_colour(
      input btn_state_t s,
      input logic       status,
      input logic       recv,
      input logic       send,
      input logic       blink
   );
      logic [PIX_W-1:0] normal;
      logic [PIX_W-1:0] res;
      case (s)
         HOVER:   normal = TOUCH;
         PRESSED: normal = CLICK;
         default: normal = BLACK;
      endcase
      res = normal;
      if (status) begin
         if (recv && send)  res = LINKED;
         else if (recv)     res = (s == PRESSED) ? CLICK : RECV;
         else if (send)     res = blink ? SEND : BLACK;
      end
      return res;
   endfunction

endpackage

// File: rtl/menu_button_fsm.sv
// Hover/press/click tracker for one button.
// Ports: clk, rst (sync, active-high); mouse_on_k cursor inside this button;
//        rise/fall mouse_left edges; state current FSM state; click one-cycle registered pulse.
module menu_button_fsm
   import menu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       mouse_on_k,
   input  logic       rise,
   input  logic       fall,
   output btn_state_t state,
   output logic       click
);

   btn_state_t state_q, state_d;
   logic       click_q, click_d;

   // State and click registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         click_q <= 1'b0;
      end else begin
         state_q <= state_d;
         click_q <= click_d;
      end
   end

   // Leaving the button always wins over a release, so drag-out cancels the click.
   always_comb begin
      state_d = state_q;
      click_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (mouse_on_k) state_d = HOVER;
         end
         HOVER: begin
            if (!mouse_on_k) state_d = IDLE;
            else if (rise)   state_d = PRESSED;
         end
         PRESSED: begin
            if (!mouse_on_k) begin
               state_d = IDLE;
            end else if (fall) begin
               state_d = HOVER;
               click_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign state = state_q;
   assign click = click_q;

endmodule

// File: rtl/menu_button_pixel_gen.sv
// Menu renderer: addresses an external label-mask ROM, maps region codes to RGB
// and tracks per-button hover/press/click state.
// Ports: clk, rst (sync, active-high); pix_en/h_cnt/v_cnt pixel timing; mouse_left,
//        mouse_on[] cursor info; receive_connect/send_connect link status;
//        mem_addr/mem_data ROM interface; pixel_out/pixel_valid pixel stream
//        (MEM_LATENCY+2 cycles after h_cnt/v_cnt); click[] one-cycle click pulses.
module menu_button_pixel_gen
   import menu_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS  = 2,
   parameter int unsigned CODE_W       = 2,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned IMG_W        = 320,
   parameter int unsigned IMG_H        = 240,
   parameter int unsigned SCALE_SHIFT  = 1,
   parameter logic [7:0]  STATUS_MASK  = 8'b10,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pix_en,
   input  logic [9:0]             h_cnt,
   input  logic [9:0]             v_cnt,
   input  logic                   mouse_left,
   input  logic [NUM_BUTTONS-1:0] mouse_on,
   input  logic                   receive_connect,
   input  logic                   send_connect,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic [CODE_W-1:0]      mem_data,
   output logic [PIX_W-1:0]       pixel_out,
   output logic                   pixel_valid,
   output logic [NUM_BUTTONS-1:0] click
);

   localparam int unsigned CALC_W = 24;
   localparam logic [CALC_W-1:0] IMG_SIZE = CALC_W'(IMG_W * IMG_H);
   localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic                   v1_q;
   logic                   fs1_q, fs1_d;
   logic [MEM_LATENCY-1:0] vpipe_q, vpipe_d;
   logic                   ml_q;
   logic                   armed_q;
   logic [FC_W-1:0]        frame_q, frame_d;
   logic                   blink_q, blink_d;
   logic [PIX_W-1:0]       pixel_q, pixel_d;
   logic                   valid_q;
   logic [CALC_W-1:0]      addr_raw;
   logic [CALC_W-1:0]      addr_wrap;
   logic                   rise, fall;
   logic [PIX_W-1:0]       colour;
   btn_state_t             btn_state [NUM_BUTTONS];

   // Image address from scaled screen position; a single subtraction folds the overscan rows.
   always_comb begin
      addr_raw   = CALC_W'(h_cnt >> SCALE_SHIFT) + CALC_W'(IMG_W) * CALC_W'(v_cnt >> SCALE_SHIFT);
      addr_wrap  = (addr_raw >= IMG_SIZE) ? (addr_raw - IMG_SIZE) : addr_raw;
      mem_addr_d = ADDR_W'(addr_wrap);
      fs1_d      = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);
   end

   // Valid delay line matching the ROM read latency.
   assign vpipe_d = MEM_LATENCY'({vpipe_q, v1_q});

   // A button held through reset is not armed until it has been seen released.
   assign rise = mouse_left & ~ml_q & armed_q;
   assign fall = ~mouse_left & ml_q;

   // Blink frame counter, advanced on the registered frame-start flag.
   always_comb begin
      frame_d = frame_q;
      blink_d = blink_q;
      if (fs1_q) begin
         if (frame_q == FC_W'(BLINK_FRAMES - 1)) begin
            frame_d = '0;
            blink_d = ~blink_q;
         end else begin
            frame_d = frame_q + FC_W'(1);
         end
      end
   end

   // Code decode using FSM state and link inputs as seen in the final-stage cycle.
   always_comb begin
      colour = WHITE;
      if (mem_data == '0) colour = BLACK;
      for (int k = 0; k < NUM_BUTTONS; k++) begin
         if (mem_data == CODE_W'(BTN_CODE_BASE + k))
            colour = button_colour(btn_state[k], STATUS_MASK[k], receive_connect,
                                   send_connect, blink_q);
      end
      pixel_d = vpipe_q[MEM_LATENCY-1] ? colour : BLACK;
   end

   // Pipeline, mouse history and blink registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr_q <= '0;
         v1_q       <= 1'b0;
         fs1_q      <= 1'b0;
         vpipe_q    <= '0;
         ml_q       <= 1'b0;
         armed_q    <= 1'b0;
         frame_q    <= '0;
         blink_q    <= 1'b0;
         pixel_q    <= BLACK;
         valid_q    <= 1'b0;
      end else begin
         mem_addr_q <= mem_addr_d;
         v1_q       <= pix_en;
         fs1_q      <= fs1_d;
         vpipe_q    <= vpipe_d;
         ml_q       <= mouse_left;
         armed_q    <= armed_q | ~mouse_left;
         frame_q    <= frame_d;
         blink_q    <= blink_d;
         pixel_q    <= pixel_d;
         valid_q    <= vpipe_q[MEM_LATENCY-1];
      end
   end

   for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_btn
      menu_button_fsm u_fsm (
         .clk        (clk),
         .rst        (rst),
         .mouse_on_k (mouse_on[k]),
         .rise       (rise),
         .fall       (fall),
         .state      (btn_state[k]),
         .click      (click[k])
      );
   end

   assign mem_addr    = mem_addr_q;
   assign pixel_out   = pixel_q;
   assign pixel_valid = valid_q;

endmodule

// File: tb/tb_menu_button_pixel_gen.sv
// Self-checking bench for menu_button_pixel_gen: vector table plus hand-written
// mouse/link/reset sequences, with a pixel scoreboard fed by a behavioural ROM.
module tb_menu_button_pixel_gen;

   localparam int unsigned L = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_en;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        mouse_left;
   logic [1:0]  mouse_on;
   logic        receive_connect;
   logic        send_connect;
   logic [16:0] mem_addr;
   logic [2:0]  mem_data;
   logic [11:0] pixel_out;
   logic        pixel_valid;
   logic [1:0]  click;

   int tests = 0;
   int fails = 0;
   logic mon_en = 1'b0;

   typedef struct {
      string       tag;
      logic [11:0] pix;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        recv;
      logic        send;
      logic [16:0] addr;
      logic [11:0] pix;
   } vec_t;
   vec_t vecs [13];

   menu_button_pixel_gen #(
      .NUM_BUTTONS (2),
      .CODE_W      (3),
      .MEM_LATENCY (L),
      .IMG_W       (320),
      .IMG_H       (240),
      .SCALE_SHIFT (1),
      .STATUS_MASK (8'b10),
      .BLINK_FRAMES(2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pix_en          (pix_en),
      .h_cnt           (h_cnt),
      .v_cnt           (v_cnt),
      .mouse_left      (mouse_left),
      .mouse_on        (mouse_on),
      .receive_connect (receive_connect),
      .send_connect    (send_connect),
      .mem_addr        (mem_addr),
      .mem_data        (mem_data),
      .pixel_out       (pixel_out),
      .pixel_valid     (pixel_valid),
      .click           (click)
   );

   always #5 clk = ~clk;

   // ROM model: code is the low three address bits, two-cycle read latency.
   logic [2:0] rp0, rp1;
   always @(posedge clk) begin
      rp0 <= mem_addr[2:0];
      rp1 <= rp0;
   end
   assign mem_data = rp1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every valid pixel pops one expectation; invalid pixels must be black.
   always begin
      @(posedge clk);
      #1;
      if (mon_en) begin
         if (pixel_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pixel: got %0h with nothing expected", pixel_out);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check(e.tag, {20'h0, pixel_out}, {20'h0, e.pix});
            end
         end else begin
            check("black_when_invalid", {20'h0, pixel_out}, 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One visible pixel, then let it drain before inputs change again.
   task automatic put_pixel(input logic [9:0] h, input logic [9:0] v,
                            input logic [11:0] exp, input string tag);
      @(negedge clk);
      h_cnt  = h;
      v_cnt  = v;
      pix_en = 1'b1;
      exp_q.push_back('{tag, exp});
      @(negedge clk);
      pix_en = 1'b0;
      repeat (L + 2) @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{10'd2,   10'd0,   1'b0, 1'b0, 17'd1,     12'hFFF};
      vecs[1]  = '{10'd4,   10'd0,   1'b0, 1'b0, 17'd2,     12'h000};
      vecs[2]  = '{10'd6,   10'd1,   1'b0, 1'b0, 17'd3,     12'h000};
      vecs[3]  = '{10'd6,   10'd1,   1'b1, 1'b0, 17'd3,     12'h7FF};
      vecs[4]  = '{10'd6,   10'd1,   1'b1, 1'b1, 17'd3,     12'h1E1};
      vecs[5]  = '{10'd4,   10'd0,   1'b1, 1'b1, 17'd2,     12'h000};
      vecs[6]  = '{10'd8,   10'd0,   1'b0, 1'b0, 17'd4,     12'hFFF};
      vecs[7]  = '{10'd14,  10'd0,   1'b0, 1'b0, 17'd7,     12'hFFF};
      vecs[8]  = '{10'd639, 10'd524, 1'b0, 1'b0, 17'd7359,  12'hFFF};
      vecs[9]  = '{10'd639, 10'd479, 1'b0, 1'b0, 17'd76799, 12'hFFF};
      vecs[10] = '{10'd0,   10'd480, 1'b0, 1'b0, 17'd0,     12'h000};
      vecs[11] = '{10'd6,   10'd1,   1'b0, 1'b1, 17'd3,     12'h000};
      vecs[12] = '{10'd10,  10'd2,   1'b0, 1'b0, 17'd325,   12'hFFF};

      rst = 1'b1; pix_en = 1'b0; h_cnt = '0; v_cnt = '0;
      mouse_left = 1'b0; mouse_on = 2'b00; receive_connect = 1'b0; send_connect = 1'b0;

      // Reset values.
      idle(2);
      check("rst_mem_addr", {15'h0, mem_addr}, 32'h0);
      check("rst_pixel_out", {20'h0, pixel_out}, 32'h0);
      check("rst_pixel_valid", {31'h0, pixel_valid}, 32'h0);
      check("rst_click", {30'h0, click}, 32'h0);
      rst = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // Static decode / address table.
      foreach (vecs[i]) begin
         @(negedge clk);
         receive_connect = vecs[i].recv;
         send_connect    = vecs[i].send;
         h_cnt  = vecs[i].h;
         v_cnt  = vecs[i].v;
         pix_en = 1'b1;
         exp_q.push_back('{$sformatf("vec%0d_pixel", i), vecs[i].pix});
         @(negedge clk);
         check($sformatf("vec%0d_addr", i), {15'h0, mem_addr}, {15'h0, vecs[i].addr});
         pix_en = 1'b0;
         repeat (L + 2) @(negedge clk);
      end
      receive_connect = 1'b0;
      send_connect    = 1'b0;

      // Latency: exactly L+2 cycles, invalid on either side.
      @(negedge clk);
      h_cnt = 10'd2; v_cnt = 10'd0; pix_en = 1'b1;
      exp_q.push_back('{"latency_pixel", 12'hFFF});
      @(negedge clk);
      pix_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("latency_early", {31'h0, pixel_valid}, 32'h0);
      @(negedge clk);
      check("latency_on_time", {31'h0, pixel_valid}, 32'h1);
      @(negedge clk);
      check("latency_late", {31'h0, pixel_valid}, 32'h0);
      idle(2);

      // Click on button 0: hover, press, release inside.
      mouse_on = 2'b01;
      idle(2);
      put_pixel(10'd4, 10'd0, 12'h32E, "click_hover");
      mouse_left = 1'b1;
      idle(2);
      check("click_while_pressed", {30'h0, click}, 32'h0);
      put_pixel(10'd4, 10'd0, 12'hDD2, "click_pressed");
      @(negedge clk);
      mouse_left = 1'b0;
      @(negedge clk);
      check("click_pulse", {30'h0, click}, 32'h1);
      @(negedge clk);
      check("click_pulse_end", {30'h0, click}, 32'h0);
      put_pixel(10'd4, 10'd0, 12'h32E, "click_after_release");

      // Cancel: press then leave before release.
      mouse_left = 1'b1;
      idle(2);
      mouse_on = 2'b00;
      idle(2);
      mouse_left = 1'b0;
      @(negedge clk);
      check("cancel_no_click_a", {30'h0, click}, 32'h0);
      @(negedge clk);
      check("cancel_no_click_b", {30'h0, click}, 32'h0);
      put_pixel(10'd4, 10'd0, 12'h000, "cancel_idle");

      // Drag-in: press outside, then enter; must stay HOVER.
      mouse_left = 1'b1;
      idle(2);
      mouse_on = 2'b01;
      idle(2);
      put_pixel(10'd4, 10'd0, 12'h32E, "dragin_hover");
      mouse_left = 1'b0;
      @(negedge clk);
      check("dragin_no_click_a", {30'h0, click}, 32'h0);
      @(negedge clk);
      check("dragin_no_click_b", {30'h0, click}, 32'h0);

      // Release and exit in the same cycle.
      mouse_left = 1'b1;
      idle(2);
      mouse_on = 2'b00;
      mouse_left = 1'b0;
      @(negedge clk);
      check("same_cycle_no_click_a", {30'h0, click}, 32'h0);
      @(negedge clk);
      check("same_cycle_no_click_b", {30'h0, click}, 32'h0);
      put_pixel(10'd4, 10'd0, 12'h000, "same_cycle_idle");

      // Status button pressed with receive only shows CLICK.
      mouse_on = 2'b10;
      idle(2);
      mouse_left = 1'b1;
      idle(2);
      receive_connect = 1'b1;
      put_pixel(10'd6, 10'd1, 12'hDD2, "recv_pressed");
      mouse_left = 1'b0;
      @(negedge clk);
      check("btn1_click_pulse", {30'h0, click}, 32'h2);
      receive_connect = 1'b0;
      mouse_on = 2'b00;
      idle(2);

      // Blink: send only, phase toggles every second frame start.
      send_connect = 1'b1;
      put_pixel(10'd6, 10'd1, 12'h000, "blink_phase0");
      put_pixel(10'd0, 10'd0, 12'h000, "frame_start");
      put_pixel(10'd6, 10'd1, 12'h000, "blink_one_frame");
      put_pixel(10'd0, 10'd0, 12'h000, "frame_start");
      put_pixel(10'd6, 10'd1, 12'h456, "blink_phase1");
      put_pixel(10'd0, 10'd0, 12'h000, "frame_start");
      put_pixel(10'd0, 10'd0, 12'h000, "frame_start");
      put_pixel(10'd6, 10'd1, 12'h000, "blink_phase0_again");
      send_connect = 1'b0;

      // Reset mid-frame with button 0 pressed and held.
      mouse_on = 2'b01;
      idle(2);
      mouse_left = 1'b1;
      idle(2);
      put_pixel(10'd4, 10'd0, 12'hDD2, "pre_reset_pressed");
      @(negedge clk);
      h_cnt = 10'd4; v_cnt = 10'd0; pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("reset_valid", {31'h0, pixel_valid}, 32'h0);
      check("reset_click", {30'h0, click}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      put_pixel(10'd4, 10'd0, 12'h32E, "held_after_reset_hover");
      mouse_left = 1'b0;
      @(negedge clk);
      check("reset_release_no_click_a", {30'h0, click}, 32'h0);
      @(negedge clk);
      check("reset_release_no_click_b", {30'h0, click}, 32'h0);
      mouse_left = 1'b1;
      idle(2);
      put_pixel(10'd4, 10'd0, 12'hDD2, "repress_after_reset");
      mouse_left = 1'b0;
      @(negedge clk);
      check("repress_click", {30'h0, click}, 32'h1);
      mouse_on = 2'b00;
      idle(L + 4);

      check("scoreboard_empty", exp_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
